axi_fifo_ctrl: RTL and testbench
================================

// Module: axi_fifo_ctrl
// PURPOSE
//  Pointer/flag controller for the single-clock AXI FIFO. Sequences write and read address
//  generation for a dual-port RAM (1-cycle synchronous read), qualifies write/read requests
//  against full/empty, and produces occupancy, almost-full/almost-empty and flush control.
//  Sits between the AXI-side handshakes and the storage RAM; the RAM itself is external.
// PARAMETERS
//  ADDR_WIDTH  5   RAM address width; depth DEPTH = 2**ADDR_WIDTH (32)
//  AF_THRESH   28  o_almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   4   o_almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  i_clk           in   1             clock, all logic on rising edge
//  i_rst_n         in   1             reset, asynchronous, active-low
//  i_wr_valid      in   1             write request (data on RAM port externally)
//  o_wr_ready      out  1             write accepted this cycle iff i_wr_valid & o_wr_ready
//  i_rd_en         in   1             read request
//  o_mem_we        out  1             RAM write enable (= write accepted)
//  o_mem_waddr     out  ADDR_WIDTH    RAM write address (current wptr low bits)
//  o_mem_re        out  1             RAM read enable (= read accepted)
//  o_mem_raddr     out  ADDR_WIDTH    RAM read address (current rptr low bits)
//  o_rd_data_vld   out  1             RAM read data valid, 1 cycle after o_mem_re
//  i_flush         in   1             flush request (level; sampled in S_RUN)
//  o_flush_busy    out  1             high while state != S_RUN
//  o_full          out  1             count == DEPTH
//  o_empty         out  1             count == 0
//  o_almost_full   out  1             count >= AF_THRESH
//  o_almost_empty  out  1             count <= AE_THRESH
//  o_count         out  ADDR_WIDTH+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Pointers wptr/rptr are ADDR_WIDTH+1 bits; MSB is wrap bit; low bits drive RAM addresses.
//    Increment modulo 2**(ADDR_WIDTH+1); address wraps DEPTH-1 -> 0 naturally.
//  - count = wptr - rptr (ADDR_WIDTH+1-bit unsigned); full = MSBs differ & low bits equal;
//    empty = wptr == rptr. All flags/count registered, updated the cycle after pointer change.
//  - o_wr_ready = (state==S_RUN) & ~o_full. Write accept: wptr+1 next edge.
//  - Read accept = i_rd_en & (state==S_RUN) & ~o_empty; o_mem_re combinational from it;
//    rptr+1 next edge; o_rd_data_vld registered copy of read accept. No fall-through:
//    a write to an empty FIFO is readable no earlier than the following cycle.
//  - Simultaneous write+read accept: both pointers advance, count unchanged. When full, read
//    accepted and write refused in the same cycle (ready reflects current full).
//  - Reads/writes while full/empty are dropped, no pointer change, no error output.
//  - FSM (enum in package): S_INIT -> S_RUN unconditionally after one cycle (all accepts off).
//    S_RUN -> S_FLUSH when i_flush=1. S_FLUSH: no accepts, wptr=rptr=0 at next edge,
//    o_rd_data_vld still fires for a read accepted the cycle before; S_FLUSH -> S_RUN next
//    cycle if i_flush=0, else remain in S_FLUSH.
//  - Reset (async, any time incl. mid-transfer): state=S_INIT, wptr=rptr=0, o_count=0,
//    o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_rd_data_vld=0,
//    o_flush_busy=1, o_wr_ready=0, o_mem_we=0, o_mem_re=0, addresses 0.
// STRUCTURE
//  - Package axi_fifo_pkg: fifo_state_e {S_INIT,S_RUN,S_FLUSH}; function ptr_count(w,r).
//  - Sub-module fifo_ptr (ADDR_WIDTH): (ADDR_WIDTH+1)-bit counter with i_inc, i_clr
//    (sync, priority over inc), async reset; instantiated twice (write, read).
//  - Top holds FSM, accept logic, registered flags/count, o_rd_data_vld register.
// TESTING
//  1 Reset release -> 1 cycle S_INIT with o_wr_ready=0, then o_wr_ready=1, o_empty=1, count=0.
//  2 32 writes, no reads -> waddr 0..31, o_full=1, count=32, o_almost_full from count 28,
//    33rd write refused (o_mem_we=0, wptr unchanged).
//  3 Drain 32 reads -> raddr 0..31, o_rd_data_vld each 1 cycle later, o_empty=1; 33rd
//    i_rd_en gives o_mem_re=0; o_almost_empty asserted once count <= 4.
//  4 Full, then write+read same cycle -> read accepted, write refused, count 31; half-full
//    with both -> count unchanged, both pointers +1; wrap past address 31 -> 0 checked.
//  5 count=10, pulse i_flush 1 cycle -> o_flush_busy=1 one cycle, then count=0, o_empty=1,
//    next write at waddr 0.
//  6 Assert i_rst_n=0 asynchronously mid-burst (count=17) -> all outputs at reset values
//    before next clock edge; after release, normal operation from address 0.

Source files
------------

// File: rtl/axi_fifo_pkg.sv
// axi_fifo_pkg: shared FSM state type and pointer helpers for the AXI FIFO controller.
package axi_fifo_pkg;
  typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} fifo_state_e;
  function automatic logic [31:0] ptr_count(input logic [31:0] w, input logic [31:0] r);
    return w - r;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit pointer counter with sync clear taking priority over increment.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_inc,
  input  logic                i_clr,
  output logic [ADDR_WIDTH:0] o_ptr,
  output logic [ADDR_WIDTH:0] o_ptr_d
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = i_clr ? '0 : ptr_q + PW'(i_inc);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign o_ptr   = ptr_q;
  assign o_ptr_d = ptr_d;
endmodule

// File: rtl/axi_fifo_ctrl.sv
// axi_fifo_ctrl: pointer/flag controller for a single-clock FIFO around an external
// dual-port RAM with 1-cycle synchronous read.
module axi_fifo_ctrl
  import axi_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic                  i_rd_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic                  o_mem_re,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  output logic                  o_rd_data_vld,
  input  logic                  i_flush,
  output logic                  o_flush_busy,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(2 ** ADDR_WIDTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);
  fifo_state_e   state_q, state_d;
  logic [PW-1:0] wptr, wptr_nxt, rptr, rptr_nxt, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d, rd_vld_q, rd_vld_d;
  logic          run, clr, wr_acc, rd_acc;
  assign run    = state_q == S_RUN;
  assign clr    = state_q == S_FLUSH;
  assign wr_acc = i_wr_valid & run & ~full_q;
  assign rd_acc = i_rd_en & run & ~empty_q;
  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(wr_acc), .i_clr(clr), .o_ptr(wptr), .o_ptr_d(wptr_nxt)
  );
  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(rd_acc), .i_clr(clr), .o_ptr(rptr), .o_ptr_d(rptr_nxt)
  );
  always_comb state_d = state_q == S_INIT ? S_RUN : (i_flush ? S_FLUSH : S_RUN);
  // Flags come from next-pointer values so they land on the same edge as the pointers.
  always_comb begin
    count_d  = PW'(ptr_count(32'(wptr_nxt), 32'(rptr_nxt)));
    full_d   = count_d == DEPTH_C;
    empty_d  = count_d == '0;
    af_d     = count_d >= AF_C;
    ae_d     = count_d <= AE_C;
    rd_vld_d = rd_acc;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q  <= S_INIT;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      rd_vld_q <= rd_vld_d;
    end
  assign o_wr_ready     = run & ~full_q;
  assign o_mem_we       = wr_acc;
  assign o_mem_waddr    = wptr[ADDR_WIDTH-1:0];
  assign o_mem_re       = rd_acc;
  assign o_mem_raddr    = rptr[ADDR_WIDTH-1:0];
  assign o_rd_data_vld  = rd_vld_q;
  assign o_flush_busy   = ~run;
  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
  assign o_count        = count_q;
endmodule

// File: tb/tb_axi_fifo_ctrl.sv
// tb_axi_fifo_ctrl: directed scenarios for axi_fifo_ctrl with hand-derived expectations.
module tb_axi_fifo_ctrl;
  logic       clk, rst_n, wr_valid, wr_ready, rd_en, mem_we, mem_re, rd_vld, flush, busy;
  logic       full, empty, af, ae;
  logic [4:0] waddr, raddr;
  logic [5:0] count;
  int n_cmp = 0, n_err = 0;

  axi_fifo_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_rd_en(rd_en), .o_mem_we(mem_we), .o_mem_waddr(waddr), .o_mem_re(mem_re),
    .o_mem_raddr(raddr), .o_rd_data_vld(rd_vld), .i_flush(flush), .o_flush_busy(busy),
    .o_full(full), .o_empty(empty), .o_almost_full(af), .o_almost_empty(ae), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", busy); end n_cmp++;
    if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end n_cmp++;
    if (count !== 6'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end n_cmp++;
    rst_n = 1'b1;
    #1;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL init_wr_ready: got %b want 0", wr_ready); end n_cmp++;
    if (ae !== 1'b1 || af !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL init_flags: got ae=%b af=%b full=%b want 1 0 0", ae, af, full); end n_cmp++;
    step;
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL run_wr_ready: got %b want 1", wr_ready); end n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL run_busy: got %b want 0", busy); end n_cmp++;
    if (empty !== 1'b1 || count !== 6'd0) begin n_err++; $display("FAIL run_empty: got empty=%b count=%0d want 1 0", empty, count); end n_cmp++;
  endtask

  task automatic test_fill;
    wr_valid = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      if (mem_we !== 1'b1 || waddr !== 5'(i)) begin n_err++; $display("FAIL fill_we[%0d]: got we=%b addr=%0d want 1 %0d", i, mem_we, waddr, i); end n_cmp++;
      if (count !== 6'(i) || full !== 1'b0) begin n_err++; $display("FAIL fill_count[%0d]: got %0d full=%b want %0d 0", i, count, full, i); end n_cmp++;
      if (af !== (i >= 28)) begin n_err++; $display("FAIL fill_af[%0d]: got %b want %b", i, af, (i >= 28)); end n_cmp++;
      step;
    end
    if (full !== 1'b1 || count !== 6'd32 || af !== 1'b1) begin n_err++; $display("FAIL full_flags: got full=%b count=%0d af=%b want 1 32 1", full, count, af); end n_cmp++;
    if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL full_refuse: got ready=%b we=%b want 0 0", wr_ready, mem_we); end n_cmp++;
    step;
    if (count !== 6'd32 || waddr !== 5'd0) begin n_err++; $display("FAIL full_hold: got count=%0d waddr=%0d want 32 0", count, waddr); end n_cmp++;
    wr_valid = 1'b0;
  endtask

  task automatic test_drain;
    rd_en = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      if (mem_re !== 1'b1 || raddr !== 5'(i)) begin n_err++; $display("FAIL drain_re[%0d]: got re=%b addr=%0d want 1 %0d", i, mem_re, raddr, i); end n_cmp++;
      if (count !== 6'(32 - i)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 32 - i); end n_cmp++;
      if (ae !== (i >= 28)) begin n_err++; $display("FAIL drain_ae[%0d]: got %b want %b", i, ae, (i >= 28)); end n_cmp++;
      if (rd_vld !== (i > 0)) begin n_err++; $display("FAIL drain_vld[%0d]: got %b want %b", i, rd_vld, (i > 0)); end n_cmp++;
      step;
    end
    if (mem_re !== 1'b0 || rd_vld !== 1'b1) begin n_err++; $display("FAIL empty_re: got re=%b vld=%b want 0 1", mem_re, rd_vld); end n_cmp++;
    if (empty !== 1'b1 || count !== 6'd0 || ae !== 1'b1 || af !== 1'b0) begin n_err++; $display("FAIL empty_flags: got empty=%b count=%0d ae=%b af=%b want 1 0 1 0", empty, count, ae, af); end n_cmp++;
    step;
    if (rd_vld !== 1'b0 || raddr !== 5'd0) begin n_err++; $display("FAIL empty_hold: got vld=%b raddr=%0d want 0 0", rd_vld, raddr); end n_cmp++;
    rd_en = 1'b0;
  endtask

  task automatic test_simul;
    wr_valid = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      if (waddr !== 5'(i)) begin n_err++; $display("FAIL refill_addr[%0d]: got %0d want %0d", i, waddr, i); end n_cmp++;
      step;
    end
    rd_en = 1'b1;
    #1;
    if (full !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b1 || raddr !== 5'd0) begin n_err++; $display("FAIL full_both: got full=%b we=%b re=%b raddr=%0d want 1 0 1 0", full, mem_we, mem_re, raddr); end n_cmp++;
    step;
    if (count !== 6'd31 || full !== 1'b0 || wr_ready !== 1'b1) begin n_err++; $display("FAIL full_both_after: got count=%0d full=%b ready=%b want 31 0 1", count, full, wr_ready); end n_cmp++;
    wr_valid = 1'b0;
    #1;
    for (int i = 1; i < 16; i++) begin
      if (raddr !== 5'(i)) begin n_err++; $display("FAIL half_raddr[%0d]: got %0d want %0d", i, raddr, i); end n_cmp++;
      step;
    end
    wr_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (mem_we !== 1'b1 || mem_re !== 1'b1) begin n_err++; $display("FAIL both_acc[%0d]: got we=%b re=%b want 1 1", i, mem_we, mem_re); end n_cmp++;
      if (waddr !== 5'(i) || raddr !== 5'(16 + i)) begin n_err++; $display("FAIL both_addr[%0d]: got w=%0d r=%0d want %0d %0d", i, waddr, raddr, i, (16 + i) % 32); end n_cmp++;
      if (count !== 6'd16) begin n_err++; $display("FAIL both_count[%0d]: got %0d want 16", i, count); end n_cmp++;
      step;
    end
    wr_valid = 1'b0;
    repeat (6) step;
    rd_en = 1'b0;
    #1;
    if (count !== 6'd10 || raddr !== 5'd10 || waddr !== 5'd20) begin n_err++; $display("FAIL pre_flush: got count=%0d r=%0d w=%0d want 10 10 20", count, raddr, waddr); end n_cmp++;
  endtask

  task automatic test_flush;
    flush = 1'b1; rd_en = 1'b1;
    #1;
    if (busy !== 1'b0 || mem_re !== 1'b1) begin n_err++; $display("FAIL flush_req: got busy=%b re=%b want 0 1", busy, mem_re); end n_cmp++;
    step;
    flush = 1'b0; wr_valid = 1'b1;
    #1;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin n_err++; $display("FAIL flush_busy: got busy=%b ready=%b want 1 0", busy, wr_ready); end n_cmp++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_err++; $display("FAIL flush_noacc: got we=%b re=%b want 0 0", mem_we, mem_re); end n_cmp++;
    if (rd_vld !== 1'b1 || count !== 6'd9) begin n_err++; $display("FAIL flush_vld: got vld=%b count=%0d want 1 9", rd_vld, count); end n_cmp++;
    step;
    if (busy !== 1'b0 || count !== 6'd0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_done: got busy=%b count=%0d empty=%b want 0 0 1", busy, count, empty); end n_cmp++;
    if (mem_we !== 1'b1 || waddr !== 5'd0 || mem_re !== 1'b0 || rd_vld !== 1'b0) begin n_err++; $display("FAIL flush_restart: got we=%b waddr=%0d re=%b vld=%b want 1 0 0 0", mem_we, waddr, mem_re, rd_vld); end n_cmp++;
    rd_en = 1'b0;
    step;
    if (count !== 6'd1 || waddr !== 5'd1) begin n_err++; $display("FAIL flush_write: got count=%0d waddr=%0d want 1 1", count, waddr); end n_cmp++;
  endtask

  task automatic test_async_reset;
    for (int i = 1; i < 17; i++) begin
      if (waddr !== 5'(i)) begin n_err++; $display("FAIL burst_addr[%0d]: got %0d want %0d", i, waddr, i); end n_cmp++;
      step;
    end
    if (count !== 6'd17) begin n_err++; $display("FAIL burst_count: got %0d want 17", count); end n_cmp++;
    #3 rst_n = 1'b0;
    #1;
    if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL arst_ctl: got ready=%b we=%b re=%b busy=%b want 0 0 0 1", wr_ready, mem_we, mem_re, busy); end n_cmp++;
    if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || ae !== 1'b1 || af !== 1'b0) begin n_err++; $display("FAIL arst_flags: got count=%0d empty=%b full=%b ae=%b af=%b", count, empty, full, ae, af); end n_cmp++;
    if (waddr !== 5'd0 || raddr !== 5'd0 || rd_vld !== 1'b0) begin n_err++; $display("FAIL arst_addr: got w=%0d r=%0d vld=%b want 0 0 0", waddr, raddr, rd_vld); end n_cmp++;
    wr_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL arst_init: got %b want 0", wr_ready); end n_cmp++;
    step;
    wr_valid = 1'b1;
    #1;
    if (mem_we !== 1'b1 || waddr !== 5'd0) begin n_err++; $display("FAIL arst_resume: got we=%b waddr=%0d want 1 0", mem_we, waddr); end n_cmp++;
    step;
    wr_valid = 1'b0;
    #1;
    if (count !== 6'd1 || empty !== 1'b0) begin n_err++; $display("FAIL arst_count: got count=%0d empty=%b want 1 0", count, empty); end n_cmp++;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_simul;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
